// File: rtl/clkdiv_bank_pkg.sv
// clkdiv_bank_pkg
//   Shared constants, the per-channel configuration record and the helpers
//   that turn raw register values into the effective divisor and high time.
//   Helpers work at the widest supported field width (DIV_W_MAX). Callers
//   zero-extend their narrower fields on the way in and truncate on the way
//   out.
package clkdiv_bank_pkg;

    localparam int DIV_W_MAX = 32;
    localparam int MIN_DIV   = 2;

    typedef struct packed {
        logic [DIV_W_MAX-1:0] div;
        logic [DIV_W_MAX-1:0] high;
        logic [DIV_W_MAX-1:0] phase;
    } chan_cfg_t;

    // Divisors of 0 and 1 would give a period too short to hold both a high
    // and a low phase, so they clamp to the minimum.
    function automatic logic [DIV_W_MAX-1:0] eff_div(input logic [DIV_W_MAX-1:0] d);
        return (d < DIV_W_MAX'(MIN_DIV)) ? DIV_W_MAX'(MIN_DIV) : d;
    endfunction

    // A high time longer than the period saturates to the period (constant high).
    function automatic logic [DIV_W_MAX-1:0] eff_high(input logic [DIV_W_MAX-1:0] h,
                                                      input logic [DIV_W_MAX-1:0] deff);
        return (h > deff) ? deff : h;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan
//   One divider channel: period counter, active divisor/high-time shadows,
//   and the registered output (plus the wrap strobe when
//   CLKDIV_BANK_TICK_EN is defined).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : run enable
//   align     : re-phase strobe (counter loads the phase offset)
//   cfg       : raw divisor / high time / phase for this channel
//   out       : divided output, high while cnt < active high time
//   tick      : one-cycle strobe on period wrap (CLKDIV_BANK_TICK_EN only)
module clkdiv_chan
    import clkdiv_bank_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
)(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      align,
    input  chan_cfg_t cfg,
    output logic      out
`ifdef CLKDIV_BANK_TICK_EN
    ,
    output logic      tick
`endif
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q, dact_q, hact_q;
    logic [DIV_W-1:0] cnt_d, dact_d, hact_d;
    logic [DIV_W-1:0] deff, heff;
    logic             run_q;
    logic             wrap;

    // A wrap only counts as such while running normally; align and the
    // first enabled edge both pre-empt it.
    assign wrap = en && !align && run_q && (cnt_q == dact_q - ONE);

    always_comb begin
        deff   = DIV_W'(eff_div(cfg.div));
        heff   = DIV_W'(eff_high(cfg.high, eff_div(cfg.div)));
        cnt_d  = cnt_q;
        dact_d = dact_q;
        hact_d = hact_q;
        if (!en) begin
            cnt_d  = '0;
            dact_d = deff;
            hact_d = heff;
        end else if (align) begin
            dact_d = deff;
            hact_d = heff;
            cnt_d  = (cfg.phase < eff_div(cfg.div)) ? DIV_W'(cfg.phase) : '0;
        end else if (!run_q) begin
            // First enabled edge: hold at 0 and latch the current settings so
            // the very first period already has the programmed shape.
            cnt_d  = '0;
            dact_d = deff;
            hact_d = heff;
        end else if (wrap) begin
            // Shadows reload only here, so a period in flight keeps its length.
            cnt_d  = '0;
            dact_d = deff;
            hact_d = heff;
        end else begin
            cnt_d  = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dact_q <= DIV_W'(DEF_DIV);
            hact_q <= DIV_W'(DEF_HIGH);
            run_q  <= 1'b0;
            out    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dact_q <= dact_d;
            hact_q <= hact_d;
            run_q  <= en;
            out    <= en && (cnt_d < hact_d);
        end
    end

`ifdef CLKDIV_BANK_TICK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tick <= 1'b0;
        end else begin
            tick <= wrap;
        end
    end
`endif

endmodule

// File: rtl/clkdiv_bank.sv
// clkdiv_bank
//   Bank of N_CH independent programmable clock/pulse dividers with a shared
//   align strobe. Each channel runs period max(D,2) cycles, high for the
//   first min(H,period) of them; ratio changes land at period boundaries.
// Optional feature: define CLKDIV_BANK_TICK_EN to expose tick_o.
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   en_i       : per-channel run enable
//   div_i      : per-channel divisor, channel i at [i*DIV_W +: DIV_W]
//   high_i     : per-channel high time, same packing
//   phase_i    : per-channel phase offset loaded on align, same packing
//   align_i    : single-cycle re-phase strobe for all enabled channels
//   out_o      : divided outputs
//   tick_o     : per-channel wrap strobes (CLKDIV_BANK_TICK_EN only)
module clkdiv_bank
    import clkdiv_bank_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1
)(
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [N_CH-1:0]       en_i,
    input  logic [N_CH*DIV_W-1:0] div_i,
    input  logic [N_CH*DIV_W-1:0] high_i,
    input  logic [N_CH*DIV_W-1:0] phase_i,
    input  logic                  align_i,
`ifdef CLKDIV_BANK_TICK_EN
    output logic [N_CH-1:0]       tick_o,
`endif
    output logic [N_CH-1:0]       out_o
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        chan_cfg_t cfg;

        assign cfg = '{div:   DIV_W_MAX'(div_i[i*DIV_W +: DIV_W]),
                       high:  DIV_W_MAX'(high_i[i*DIV_W +: DIV_W]),
                       phase: DIV_W_MAX'(phase_i[i*DIV_W +: DIV_W])};

        clkdiv_chan #(
            .DIV_W    (DIV_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .clk   (Clk),
            .rst   (Reset),
            .en    (en_i[i]),
            .align (align_i),
            .cfg   (cfg),
`ifdef CLKDIV_BANK_TICK_EN
            .tick  (tick_o[i]),
`endif
            .out   (out_o[i])
        );
    end

endmodule
